// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry valid/ready output buffer.
// Ports: clk, rst (sync, active-high), serial_in, data_out/_valid/_ready, rx_busy, frame_err, overrun.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SAMPLE_TIME = SYMBOL_EDGE_TIME / 2;
  localparam int unsigned CW = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_TIME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync;
  logic            r_rx_s;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_ovr;
  logic            w_bit_hit;
  logic            w_stop_ok;
  logic            w_stop_bad;
  logic            w_go_data;
  logic            w_cnt_clr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_hit   = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    w_go_data   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_clk_cnt == SMP_LAST) begin
          w_go_data   = !r_rx_s;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == SYM_LAST) begin
          w_bit_hit = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == SYM_LAST) begin
          w_stop_ok   = r_rx_s;
          w_stop_bad  = !r_rx_s;
          w_state_nxt = r_rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Every sample point either changes state or is a data bit tick.
  assign w_cnt_clr = (w_state_nxt != r_state) || w_bit_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 1'b1;
      r_rx_s    <= 1'b1;
      r_clk_cnt <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync <= serial_in;
      r_rx_s <= r_sync;
      r_ferr <= w_stop_bad;
      r_ovr  <= 1'b0;
      if (w_cnt_clr) r_clk_cnt <= '0;
      else           r_clk_cnt <= r_clk_cnt + CW'(1);
      if (w_go_data) r_bit_cnt <= 3'd0;
      if (w_bit_hit) begin
        r_shift[r_bit_cnt] <= r_rx_s;
        r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
      // A full buffer being drained this cycle can still take the new byte.
      if (w_stop_ok) begin
        if (!r_valid || data_out_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && data_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign rx_busy        = (r_state != S_IDLE);
  assign frame_err      = r_ferr;
  assign overrun        = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// Drives 8N1 frames at a scaled baud rate and checks against a frame-level model.
module tb_uart_rx;

  localparam int BIT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_out_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCK_FREQ(2000),
    .BAUD_RATE (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .rx_busy       (rx_busy),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Passive monitor: consumed bytes and pulse counts.
  logic [7:0] rxa[$];
  int vcyc = 0;
  int nferr = 0;
  int novr = 0;
  int nboth = 0;
  int nunst = 0;
  int ndrop = 0;
  logic pv = 1'b0;
  logic phs = 1'b0;
  logic prst = 1'b1;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    if (data_out_valid === 1'b1) vcyc++;
    if (data_out_valid && data_out_ready) rxa.push_back(data_out);
    if (frame_err === 1'b1) nferr++;
    if (overrun === 1'b1) novr++;
    if (frame_err && overrun) nboth++;
    if (pv && !phs && !prst) begin
      if (!data_out_valid) ndrop++;
      else if (data_out != pd) nunst++;
    end
    pv   = data_out_valid;
    phs  = data_out_valid && data_out_ready;
    pd   = data_out;
    prst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    serial_in = v;
    repeat (BIT) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    drive(1'b0);
    for (int k = 0; k < 8; k++) drive(b[k]);
    drive(stop);
  endtask

  initial begin
    int rd;
    int s_v, s_f, s_o;
    int tmo;
    int nbad;
    logic [7:0] exp7[$];
    logic [7:0] b;
    logic       good;

    repeat (3) tick();
    check("rst_data", data_out, 8'h00);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    repeat (2 * BIT) tick();

    // 1: single byte, ready tied high
    rd = rxa.size(); s_v = vcyc; s_f = nferr; s_o = novr;
    data_out_ready = 1'b1;
    send(8'h41, 1'b1);
    repeat (2 * BIT) tick();
    check("t1_vcyc", vcyc - s_v, 1);
    check("t1_cnt", rxa.size() - rd, 1);
    if (rxa.size() > rd) check("t1_byte", rxa[rd], 8'h41);
    check("t1_ferr", nferr - s_f, 0);
    check("t1_ovr", novr - s_o, 0);
    data_out_ready = 1'b0;

    // 2: overrun with full buffer
    rd = rxa.size(); s_o = novr; s_f = nferr;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    repeat (BIT) tick();
    check("t2_ovr", novr - s_o, 1);
    check("t2_ferr", nferr - s_f, 0);
    check("t2_valid", data_out_valid, 1'b1);
    check("t2_data", data_out, 8'h00);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    tick();
    check("t2_drain", data_out_valid, 1'b0);
    check("t2_hold", data_out, 8'h00);
    check("t2_cnt", rxa.size() - rd, 1);
    if (rxa.size() > rd) check("t2_byte", rxa[rd], 8'h00);

    // 3: short low glitch
    s_v = vcyc; s_f = nferr; s_o = novr;
    serial_in = 1'b0;
    repeat (4) tick();
    serial_in = 1'b1;
    repeat (4) tick();
    check("t3_busy_in", rx_busy, 1'b1);
    repeat (3 * BIT) tick();
    check("t3_busy", rx_busy, 1'b0);
    check("t3_vcyc", vcyc - s_v, 0);
    check("t3_ferr", nferr - s_f, 0);
    check("t3_ovr", novr - s_o, 0);

    // 4: framing error then break, then recovery
    s_v = vcyc; s_f = nferr; s_o = novr;
    send(8'h55, 1'b0);
    serial_in = 1'b0;
    repeat (3 * BIT) tick();
    check("t4_break", rx_busy, 1'b1);
    serial_in = 1'b1;
    repeat (2 * BIT) tick();
    check("t4_ferr", nferr - s_f, 1);
    check("t4_vcyc", vcyc - s_v, 0);
    check("t4_idle", rx_busy, 1'b0);
    send(8'hA5, 1'b1);
    repeat (BIT) tick();
    check("t4_valid", data_out_valid, 1'b1);
    check("t4_data", data_out, 8'hA5);
    check("t4_ovr", novr - s_o, 0);

    // 5: reset mid data bit 4, buffer still full
    s_f = nferr; s_o = novr;
    b = 8'hC3;
    drive(1'b0);
    for (int k = 0; k < 4; k++) drive(b[k]);
    serial_in = b[4];
    repeat (BIT / 2) tick();
    rst = 1'b1;
    serial_in = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", data_out_valid, 1'b0);
    check("t5_data", data_out, 8'h00);
    check("t5_busy", rx_busy, 1'b0);
    repeat (12 * BIT) tick();
    check("t5_ferr", nferr - s_f, 0);
    check("t5_ovr", novr - s_o, 0);
    rd = rxa.size();
    data_out_ready = 1'b1;
    send(8'h3C, 1'b1);
    repeat (BIT) tick();
    check("t5_cnt", rxa.size() - rd, 1);
    if (rxa.size() > rd) check("t5_byte", rxa[rd], 8'h3C);
    data_out_ready = 1'b0;

    // 6: 50 bytes, random consumer delay and line gaps
    rd = rxa.size(); s_f = nferr; s_o = novr; tmo = 0;
    fork
      begin
        for (int n = 0; n < 50; n++) begin
          send(8'h41 + 8'(n), 1'b1);
          repeat ($urandom_range(0, 30)) tick();
        end
      end
      begin
        for (int n = 0; n < 50; n++) begin
          int w;
          w = 0;
          while (!data_out_valid && w < 600) begin
            tick();
            w++;
          end
          if (!data_out_valid) begin
            tmo = 1;
            break;
          end
          repeat ($urandom_range(0, 150)) tick();
          data_out_ready = 1'b1;
          tick();
          data_out_ready = 1'b0;
        end
      end
    join
    repeat (BIT) tick();
    check("t6_timeout", tmo, 0);
    check("t6_cnt", rxa.size() - rd, 50);
    for (int i = 0; i < 50 && rd + i < rxa.size(); i++)
      check("t6_byte", rxa[rd+i], 8'h41 + 8'(i));
    check("t6_ferr", nferr - s_f, 0);
    check("t6_ovr", novr - s_o, 0);

    // 7: random bytes with random stop-bit corruption
    rd = rxa.size(); s_f = nferr; s_o = novr; nbad = 0;
    data_out_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      if (good) exp7.push_back(b);
      else nbad++;
      send(b, good);
      serial_in = 1'b1;
      repeat (2 * BIT) tick();
    end
    data_out_ready = 1'b0;
    check("t7_cnt", rxa.size() - rd, exp7.size());
    for (int i = 0; i < exp7.size() && rd + i < rxa.size(); i++)
      check("t7_byte", rxa[rd+i], exp7[i]);
    check("t7_ferr", nferr - s_f, nbad);
    check("t7_ovr", novr - s_o, 0);

    check("both_pulse", nboth, 0);
    check("unstable", nunst, 0);
    check("drop", ndrop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
